// File: rtl/gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk_pkg.sv
// Shared definitions for the PRBS-7 cell stimulus/response checkers.
// Holds the checker state encoding, the PRBS-7 constants and small
// combinational helpers used by the LFSR and the xor2 checker.
package gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    localparam logic [6:0] PRBS7_LEN    = 7'd127;
    localparam int         PRBS7_TAP_HI = 32'sd6;
    localparam int         PRBS7_TAP_LO = 32'sd5;

    // Bit positions feeding the cell inputs: A = lfsr[6], B = lfsr[0].
    localparam logic [6:0] PRBS7_AB_MASK = 7'b100_0001;

    // One step of x^7 + x^6 + 1 (shift left, feedback into bit 0).
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

    // Golden xor2 response for the stimulus taken from LFSR state s.
    function automatic logic prbs7_ab_xor(input logic [6:0] s);
        return ^(s & PRBS7_AB_MASK);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__prbs7_lfsr.sv
// PRBS-7 (x^7 + x^6 + 1) Fibonacci LFSR with load and advance enables.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, loads SEED
//   load_i  : load SEED (has priority over adv_i)
//   adv_i   : advance one step
//   state_o : current 7-bit LFSR state
module gf180mcu_osu_sc_gp9t3v3__prbs7_lfsr
    import gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [6:0] state_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    // Next-state selection: load, advance or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = prbs7_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk.sv
// PRBS-7 stimulus generator and response checker for an xor2 cell.
// Drives A/B of the cell from a PRBS-7 LFSR, samples the cell Y output and
// compares it against a golden A^B stream delayed by LAT cycles.
// Ports:
//   CLK     : clock, rising edge
//   RST     : synchronous active-high reset
//   EN      : level start/hold; low aborts a run or releases DONE
//   Y_IN    : Y output of the xor2 under test
//   A_OUT   : stimulus to xor2 A (lfsr[6])
//   B_OUT   : stimulus to xor2 B (lfsr[0])
//   BUSY    : high while priming or running
//   DONE    : high after a complete 127-compare run
//   FAIL    : high whenever ERR_CNT is nonzero
//   ERR_CNT : saturating mismatch count
module gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk
    import gf180mcu_osu_sc_gp9t3v3__xor2_prbs_chk_pkg::*;
#(
    parameter int unsigned LAT  = 32'd1,
    parameter int unsigned ERRW = 32'd8,
    parameter logic [6:0]  SEED = 7'h7F
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            Y_IN,
    output logic            A_OUT,
    output logic            B_OUT,
    output logic            BUSY,
    output logic            DONE,
    output logic            FAIL,
    output logic [ERRW-1:0] ERR_CNT
);

    localparam logic [6:0]      PRIME_LAST = 7'(LAT - 32'd1);
    localparam logic [6:0]      RUN_LAST   = PRBS7_LEN - 7'd1;
    localparam logic [ERRW-1:0] ERR_MAX    = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_ONE    = {{(ERRW-1){1'b0}}, 1'b1};

    chk_state_e      state_q, state_d;
    logic [LAT-1:0]  exp_q, exp_d;
    logic [LAT:0]    exp_shift;
    logic [6:0]      cnt_q, cnt_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            busy_q, done_q, fail_q;
    logic            lfsr_load;
    logic            lfsr_adv;
    logic [6:0]      lfsr_state;
    logic            ab_xor;

    gf180mcu_osu_sc_gp9t3v3__prbs7_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_state)
    );

    assign ab_xor = prbs7_ab_xor(lfsr_state);

    // FSM next state, pipe shift, compare counter and error counter.
    // The LFSR and golden pipe keep stepping in PRIME/RUN even on the abort
    // edge; only the compare is suppressed when EN drops.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        exp_shift = {exp_q, ab_xor};
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d   = ST_PRIME;
                    lfsr_load = 1'b1;
                    cnt_d     = 7'd0;
                    err_d     = {ERRW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                lfsr_adv = 1'b1;
                exp_d    = exp_shift[LAT-1:0];
                if (!EN) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == PRIME_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_RUN: begin
                lfsr_adv = 1'b1;
                exp_d    = exp_shift[LAT-1:0];
                if (!EN) begin
                    state_d = ST_IDLE;
                end else begin
                    if ((Y_IN != exp_q[LAT-1]) && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_ONE;
                    end else begin
                        err_d = err_q;
                    end
                    if (cnt_q == RUN_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pipe, counters and registered status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            exp_q   <= {LAT{1'b0}};
            cnt_q   <= 7'd0;
            err_q   <= {ERRW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= (state_d == ST_PRIME) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            fail_q  <= (err_d != {ERRW{1'b0}});
        end
    end

    assign A_OUT   = lfsr_state[PRBS7_TAP_HI];
    assign B_OUT   = lfsr_state[0];
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign FAIL    = fail_q;
    assign ERR_CNT = err_q;

endmodule
